// File: rtl/run_ctrl_pkg.sv
// Shared types for the TINYCPU run-control sequencer: state encoding and reset state.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        HALT  = 3'd0,
        STEP  = 3'd1,
        BURST = 3'd2,
        RUN   = 3'd3,
        BREAK = 3'd4
    } run_state_t;

    localparam run_state_t RUN_STATE_RST = HALT;

endpackage

// File: rtl/run_ctrl_btn_press_det.sv
// One-flop falling-edge detector for an active-low debounced button level.
module btn_press_det (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_o
);

    logic lvl_q;

    // Resetting the level to 1 makes a button already held at reset count as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lvl_q <= 1'b1;
        else        lvl_q <= btn_n_i;
    end

    assign press_o = lvl_q & ~btn_n_i;

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer driving the core stall line: halt, step, burst, free run.
// Define RUN_CTRL_BP_EN to build the PC breakpoint comparator and BREAK state.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned PC_W    = 32,
    parameter int unsigned BURST_W = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sw_run,
    input  logic               btn_step_n,
    input  logic               btn_burst_n,
    input  logic [BURST_W-1:0] burst_len,
    input  logic [PC_W-1:0]    pc,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic               bp_valid,
    output logic               stall,
    output logic               halted,
    output logic               bp_hit,
    output logic [CNT_W-1:0]   step_cnt
);

    run_state_t         state_q, state_d;
    logic [BURST_W-1:0] burst_q, burst_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               stall_q, stall_d;
    logic               halted_q, halted_d;
    logic               bp_hit_q, bp_hit_d;
    logic               step_press, burst_press;
    logic               bp_match;

    btn_press_det u_step_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (btn_step_n),
        .press_o (step_press)
    );

    btn_press_det u_burst_det (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_n_i (btn_burst_n),
        .press_o (burst_press)
    );

`ifdef RUN_CTRL_BP_EN
    assign bp_match = bp_valid && (pc == bp_addr);
`else
    logic unused_bp;
    assign unused_bp = ^{pc, bp_addr, bp_valid};
    assign bp_match  = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        case (state_q)
            HALT: begin
                if (step_press) begin
                    state_d = STEP;
                end else if (burst_press && (burst_len != '0)) begin
                    state_d = BURST;
                    burst_d = burst_len;
                end else if (sw_run) begin
                    state_d = RUN;
                end
            end
            STEP:  state_d = HALT;
            BURST: begin
                burst_d = burst_q - 1'b1;
                if (bp_match)                        state_d = BREAK;
                else if (burst_q == BURST_W'(1))     state_d = HALT;
            end
            RUN: begin
                if (bp_match)     state_d = BREAK;
                else if (!sw_run) state_d = HALT;
            end
            BREAK: begin
                if (step_press)   state_d = STEP;
                else if (!sw_run) state_d = HALT;
            end
            default: state_d = HALT;
        endcase

        // Outputs are decoded from the next state so they line up with it after the edge.
        stall_d  = !((state_d == STEP) || (state_d == BURST) || (state_d == RUN));
        halted_d = (state_d == HALT);
`ifdef RUN_CTRL_BP_EN
        bp_hit_d = (state_d == BREAK);
`else
        bp_hit_d = 1'b0;
`endif
        cnt_d = stall_q ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN_STATE_RST;
            burst_q  <= '0;
            cnt_q    <= '0;
            stall_q  <= 1'b1;
            halted_q <= 1'b1;
            bp_hit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            halted_q <= halted_d;
            bp_hit_q <= bp_hit_d;
        end
    end

    assign stall    = stall_q;
    assign halted   = halted_q;
    assign bp_hit   = bp_hit_q;
    assign step_cnt = cnt_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed self-checking bench for run_ctrl; breakpoint steps follow RUN_CTRL_BP_EN.
module tb_run_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sw_run;
    logic        btn_step_n;
    logic        btn_burst_n;
    logic [7:0]  burst_len;
    logic [31:0] pc;
    logic [31:0] bp_addr;
    logic        bp_valid;
    logic        stall;
    logic        halted;
    logic        bp_hit;
    logic [15:0] step_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int lows, first, last, acc;

    run_ctrl #(.PC_W(32), .BURST_W(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_run      (sw_run),
        .btn_step_n  (btn_step_n),
        .btn_burst_n (btn_burst_n),
        .burst_len   (burst_len),
        .pc          (pc),
        .bp_addr     (bp_addr),
        .bp_valid    (bp_valid),
        .stall       (stall),
        .halted      (halted),
        .bp_hit      (bp_hit),
        .step_cnt    (step_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Samples stall on each of the next n falling edges.
    task automatic run_count(input int n, output int lo, output int fi, output int la);
        lo = 0; fi = -1; la = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (stall === 1'b0) begin
                lo++;
                if (fi < 0) fi = i;
                la = i;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; sw_run = 1'b0; btn_step_n = 1'b1; btn_burst_n = 1'b1;
        burst_len = 8'd0; pc = 32'h0; bp_addr = 32'h10; bp_valid = 1'b0;
        repeat (3) cyc();
        chk("rst_stall",  32'(stall), 32'd1);
        chk("rst_halted", 32'(halted), 32'd1);
        chk("rst_bp_hit", 32'(bp_hit), 32'd0);
        chk("rst_cnt",    32'(step_cnt), 32'd0);
        rst_n = 1'b1;
        cyc();

        // Held step button: one un-stalled cycle, on the first sample.
        btn_step_n = 1'b0;
        run_count(50, lows, first, last);
        chk("step_lows",   32'(lows), 32'd1);
        chk("step_first",  32'(first), 32'd0);
        chk("step_cnt",    32'(step_cnt), 32'd1);
        chk("step_halted", 32'(halted), 32'd1);
        btn_step_n = 1'b1;

        burst_len = 8'd5; btn_burst_n = 1'b0;
        run_count(20, lows, first, last);
        chk("burst5_lows",  32'(lows), 32'd5);
        chk("burst5_first", 32'(first), 32'd0);
        chk("burst5_last",  32'(last), 32'd4);
        chk("burst5_cnt",   32'(step_cnt), 32'd6);
        chk("burst5_halt",  32'(halted), 32'd1);

        btn_burst_n = 1'b1; cyc();
        burst_len = 8'd0; btn_burst_n = 1'b0;
        run_count(10, lows, first, last);
        chk("burst0_lows", 32'(lows), 32'd0);
        chk("burst0_cnt",  32'(step_cnt), 32'd6);
        btn_burst_n = 1'b1; cyc();

        // Free run for 20 cycles with a step press in the middle that must be discarded.
        sw_run = 1'b1;
        run_count(10, lows, first, last); acc = lows;
        btn_step_n = 1'b0;
        run_count(2, lows, first, last);  acc += lows;
        btn_step_n = 1'b1;
        run_count(8, lows, first, last);  acc += lows;
        chk("run_lows", 32'(acc), 32'd20);
        sw_run = 1'b0;
        run_count(10, lows, first, last);
        chk("run_after_lows", 32'(lows), 32'd0);
        chk("run_cnt",        32'(step_cnt), 32'd26);
        chk("run_halted",     32'(halted), 32'd1);

        burst_len = 8'd5; btn_step_n = 1'b0; btn_burst_n = 1'b0;
        run_count(10, lows, first, last);
        chk("simul_lows", 32'(lows), 32'd1);
        chk("simul_cnt",  32'(step_cnt), 32'd27);
        btn_step_n = 1'b1; btn_burst_n = 1'b1; cyc();

        // Reset asserted with the burst counter at 3.
        burst_len = 8'd8; btn_burst_n = 1'b0;
        repeat (6) cyc();
        chk("midburst_stall", 32'(stall), 32'd0);
        chk("midburst_cnt",   32'(step_cnt), 32'd32);
        #2 rst_n = 1'b0; btn_burst_n = 1'b1;
        #1;
        chk("async_stall",  32'(stall), 32'd1);
        chk("async_halted", 32'(halted), 32'd1);
        chk("async_cnt",    32'(step_cnt), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        run_count(5, lows, first, last);
        chk("postrst_lows", 32'(lows), 32'd0);
        chk("postrst_cnt",  32'(step_cnt), 32'd0);

`ifdef RUN_CTRL_BP_EN
        bp_valid = 1'b1; bp_addr = 32'h10; pc = 32'h0C; sw_run = 1'b1;
        cyc(); chk("bp_run0", 32'(stall), 32'd0);
        cyc(); chk("bp_run1", 32'(stall), 32'd0);
        pc = 32'h10;
        cyc();
        chk("bp_stall",  32'(stall), 32'd1);
        chk("bp_hit",    32'(bp_hit), 32'd1);
        chk("bp_halted", 32'(halted), 32'd0);
        chk("bp_cnt",    32'(step_cnt), 32'd2);
        run_count(5, lows, first, last);
        chk("bp_hold_lows", 32'(lows), 32'd0);
        chk("bp_hold_hit",  32'(bp_hit), 32'd1);
        btn_step_n = 1'b0;
        cyc();
        chk("bp_step_stall", 32'(stall), 32'd0);
        chk("bp_step_hit",   32'(bp_hit), 32'd0);
        sw_run = 1'b0; btn_step_n = 1'b1;
        cyc();
        chk("bp_step_halt", 32'(halted), 32'd1);
        chk("bp_step_cnt",  32'(step_cnt), 32'd3);
        pc = 32'h14; cyc();
        sw_run = 1'b1; pc = 32'h10;
        cyc(); chk("bp_rerun", 32'(stall), 32'd0);
        cyc(); chk("bp_rehit", 32'(bp_hit), 32'd1);
        chk("bp_recnt", 32'(step_cnt), 32'd4);
        sw_run = 1'b0;
        cyc();
        chk("bp_drop_halt", 32'(halted), 32'd1);
        chk("bp_drop_hit",  32'(bp_hit), 32'd0);

        pc = 32'h0; burst_len = 8'd3; btn_burst_n = 1'b0;
        cyc(); chk("bpb_s0", 32'(stall), 32'd0);
        cyc(); chk("bpb_s1", 32'(stall), 32'd0);
        cyc(); chk("bpb_s2", 32'(stall), 32'd0);
        pc = 32'h10;
        cyc();
        chk("bpb_hit",    32'(bp_hit), 32'd1);
        chk("bpb_halted", 32'(halted), 32'd0);
        chk("bpb_cnt",    32'(step_cnt), 32'd7);
        btn_burst_n = 1'b1;
        cyc();
        chk("bpb_exit", 32'(halted), 32'd1);
`else
        bp_valid = 1'b1; bp_addr = 32'h10; pc = 32'h10; sw_run = 1'b1;
        run_count(5, lows, first, last);
        chk("nobp_lows", 32'(lows), 32'd5);
        chk("nobp_hit",  32'(bp_hit), 32'd0);
        sw_run = 1'b0;
        cyc();
        chk("nobp_halt", 32'(halted), 32'd1);
        chk("nobp_cnt",  32'(step_cnt), 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
